// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_pkg
// Description : Shared APB bus widths, FSM state encoding and response codes.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = APB_DATA_W / 8;
  localparam int CNT_W      = 4;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  localparam logic ERR_NONE   = 1'b0;
  localparam logic ERR_DECODE = 1'b1;

endpackage : apb_pkg
`default_nettype wire

// File: rtl/apb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : apb_regfile
// Description : NUM_REGS x 32-bit storage, byte-enabled write, async read.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_regfile
  import apb_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [APB_DATA_W-1:0] wdata,
  input  logic [APB_STRB_W-1:0] wbe,
  input  logic [IDX_W-1:0]      raddr,
  output logic [APB_DATA_W-1:0] rdata
);

  logic [APB_DATA_W-1:0] r_mem [NUM_REGS];

  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      for (int b = 0; b < APB_STRB_W; b++) begin
        if (wbe[b]) begin
          r_mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = r_mem[raddr];

endmodule : apb_regfile
`default_nettype wire

// File: rtl/apb_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module      : apb_slave_regfile
// Description : APB completer with programmable wait states fronting a
//               register bank. Optional macro APB_SLV_PSTRB_EN adds pstrb.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int NUM_REGS    = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [APB_ADDR_W-1:0] paddr,
  input  logic [APB_DATA_W-1:0] pwdata,
`ifdef APB_SLV_PSTRB_EN
  input  logic [APB_STRB_W-1:0] pstrb,
`endif
  output logic [APB_DATA_W-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int              c_IDX_W = $clog2(NUM_REGS);
  localparam logic [CNT_W-1:0] c_WAIT = CNT_W'(WAIT_CYCLES);

  logic [0:0]            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [APB_ADDR_W-1:0] r_addr;
  logic                  r_write;

  logic                  w_err;
  logic                  w_last;
  logic                  w_pready;
  logic                  w_we;
  logic [c_IDX_W-1:0]    w_idx;
  logic [APB_STRB_W-1:0] w_be;
  logic [APB_DATA_W-1:0] w_rdata;

  // Anything above the bank or not word-aligned is a decode error.
  assign w_err    = (r_addr[1:0] != 2'b00) ||
                    (r_addr[APB_ADDR_W-1:2+c_IDX_W] != '0);
  assign w_idx    = r_addr[2 +: c_IDX_W];
  assign w_last   = (r_state == ST_ACCESS) && (r_cnt == '0);
  assign w_pready = w_last && psel && penable;
  assign w_we     = w_pready && r_write && !w_err;

`ifdef APB_SLV_PSTRB_EN
  assign w_be = pstrb;
`else
  assign w_be = '1;
`endif

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_write <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (psel && !penable) begin
            r_state <= ST_ACCESS;
            r_cnt   <= c_WAIT;
            r_addr  <= paddr;
            r_write <= pwrite;
          end
        end
        ST_ACCESS: begin
          // Dropping psel/penable before pready abandons the transfer.
          if (!(psel && penable)) begin
            r_state <= ST_IDLE;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  apb_regfile #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (c_IDX_W)
  ) u_regfile (
    .pclk   (pclk),
    .preset (preset),
    .we     (w_we),
    .waddr  (w_idx),
    .wdata  (pwdata),
    .wbe    (w_be),
    .raddr  (w_idx),
    .rdata  (w_rdata)
  );

  assign pready  = w_pready;
  assign pslverr = (w_last && w_err) ? ERR_DECODE : ERR_NONE;
  assign prdata  = (w_last && !r_write && !w_err) ? w_rdata : '0;

endmodule : apb_slave_regfile
`default_nettype wire

// File: tb/tb_apb_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_slave_regfile
// Description : Self-checking bench; two instances (0 and 3 wait states).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_slave_regfile;

  localparam int NREGS = 16;
  localparam int c_WAITS [2] = '{0, 3};
`ifdef APB_SLV_PSTRB_EN
  localparam bit c_STRB = 1'b1;
`else
  localparam bit c_STRB = 1'b0;
`endif

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [31:0] paddr   [2];
  logic [31:0] pwdata  [2];
  logic [3:0]  pstrb   [2];
  logic [31:0] prdata  [2];
  logic        pready  [2];
  logic        pslverr [2];

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model [2][NREGS];

  always #5 pclk = ~pclk;

  apb_slave_regfile #(.NUM_REGS(NREGS), .WAIT_CYCLES(0)) u_dut0 (
    .pclk(pclk), .preset(preset), .psel(psel[0]), .penable(penable[0]),
    .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]),
`ifdef APB_SLV_PSTRB_EN
    .pstrb(pstrb[0]),
`endif
    .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]));

  apb_slave_regfile #(.NUM_REGS(NREGS), .WAIT_CYCLES(3)) u_dut3 (
    .pclk(pclk), .preset(preset), .psel(psel[1]), .penable(penable[1]),
    .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]),
`ifdef APB_SLV_PSTRB_EN
    .pstrb(pstrb[1]),
`endif
    .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]));

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  function automatic bit is_err(logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'(4 * NREGS));
  endfunction

  // Reference: the architectural effect of a completed transfer.
  function automatic logic [31:0] model_read(int d, logic [31:0] a);
    return is_err(a) ? 32'h0 : model[d][a / 4];
  endfunction

  function automatic void model_write(int d, logic [31:0] a, logic [31:0] v, logic [3:0] s);
    logic [3:0] be;
    be = c_STRB ? s : 4'hF;
    if (is_err(a)) return;
    for (int b = 0; b < 4; b++)
      if (be[b]) model[d][a / 4][8*b +: 8] = v[8*b +: 8];
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < NREGS; r++) model[d][r] = '0;
  endfunction

  task automatic bus_idle(int d);
    @(negedge pclk);
    psel[d] = 1'b0;
    penable[d] = 1'b0;
  endtask

  // One full transfer; reports the response and the number of wait cycles.
  task automatic xfer(input int d, input bit wr, input logic [31:0] a,
                      input logic [31:0] v, input logic [3:0] s,
                      output logic [31:0] rd, output logic err, output int waits);
    @(negedge pclk);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
    paddr[d] = a; pwdata[d] = v; pstrb[d] = s;
    @(negedge pclk);
    penable[d] = 1'b1;
    waits = 0;
    #1;
    while (!pready[d] && waits < 40) begin
      if (!wr) chk("prdata_zero_in_wait", prdata[d], 32'h0);
      @(negedge pclk);
      #1;
      waits++;
    end
    if (!pready[d]) chk("pready_timeout", {31'h0, pready[d]}, 32'h1);
    rd  = prdata[d];
    err = pslverr[d];
  endtask

  task automatic run_checked(int d, bit wr, logic [31:0] a, logic [31:0] v, logic [3:0] s, string tag);
    logic [31:0] rd;
    logic        err;
    int          waits;
    logic [31:0] exp_rd;
    exp_rd = model_read(d, a);
    xfer(d, wr, a, v, s, rd, err, waits);
    chk({tag, "_waits"}, 32'(waits), 32'(c_WAITS[d]));
    chk({tag, "_pslverr"}, {31'h0, err}, {31'h0, is_err(a)});
    if (!wr) chk({tag, "_prdata"}, rd, exp_rd);
    if (wr) model_write(d, a, v, s);
  endtask

  typedef struct {
    int          d;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    bit          exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [31:0] rd;
    logic        err;
    int          waits;

    vecs[0] = '{0, 1'b1, 32'h08, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1] = '{0, 1'b0, 32'h08, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2] = '{0, 1'b1, 32'h40, 32'h11111111, 1'b1, 32'h0};
    vecs[3] = '{0, 1'b1, 32'h06, 32'h22222222, 1'b1, 32'h0};
    vecs[4] = '{0, 1'b0, 32'h40, 32'h0,        1'b1, 32'h0};
    vecs[5] = '{0, 1'b0, 32'h04, 32'h0,        1'b0, 32'h0};
    vecs[6] = '{0, 1'b0, 32'h00, 32'h0,        1'b0, 32'h0};
    vecs[7] = '{1, 1'b0, 32'h04, 32'h0,        1'b0, 32'h0};
    vecs[8] = '{1, 1'b1, 32'h0C, 32'h0BADCAFE, 1'b0, 32'h0};
    vecs[9] = '{1, 1'b0, 32'h0C, 32'h0,        1'b0, 32'h0BADCAFE};

    for (int d = 0; d < 2; d++) begin
      psel[d] = 0; penable[d] = 0; pwrite[d] = 0;
      paddr[d] = '0; pwdata[d] = '0; pstrb[d] = 4'hF;
    end
    model_reset();
    preset = 1'b1;
    repeat (3) @(negedge pclk);
    preset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_pready", {31'h0, pready[d]}, 32'h0);
      chk("reset_pslverr", {31'h0, pslverr[d]}, 32'h0);
      chk("reset_prdata", prdata[d], 32'h0);
    end

    for (int i = 0; i < 10; i++) begin
      xfer(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].data, 4'hF, rd, err, waits);
      chk("vec_waits", 32'(waits), 32'(c_WAITS[vecs[i].d]));
      chk("vec_pslverr", {31'h0, err}, {31'h0, vecs[i].exp_err});
      if (!vecs[i].wr) chk("vec_prdata", rd, vecs[i].exp_rd);
      if (vecs[i].wr) model_write(vecs[i].d, vecs[i].addr, vecs[i].data, 4'hF);
    end
    bus_idle(0);
    bus_idle(1);

    // Abort a waited write mid-wait; the old value must survive.
    @(negedge pclk);
    psel[1] = 1; penable[1] = 0; pwrite[1] = 1; paddr[1] = 32'h0C; pwdata[1] = 32'h12345678; pstrb[1] = 4'hF;
    @(negedge pclk);
    penable[1] = 1;
    #1 chk("abort_pready_a", {31'h0, pready[1]}, 32'h0);
    @(negedge pclk);
    psel[1] = 0; penable[1] = 0;
    #1 chk("abort_pready_b", {31'h0, pready[1]}, 32'h0);
    repeat (4) begin
      @(negedge pclk);
      #1 chk("abort_pready_c", {31'h0, pready[1]}, 32'h0);
    end
    run_checked(1, 1'b0, 32'h0C, 32'h0, 4'hF, "abort_read");
    bus_idle(1);

`ifdef APB_SLV_PSTRB_EN
    run_checked(0, 1'b1, 32'h10, 32'h11223344, 4'hF, "strb_full");
    run_checked(0, 1'b1, 32'h10, 32'hAABBCCDD, 4'b0101, "strb_part");
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, err, waits);
    chk("strb_readback", rd, 32'h11BB33DD);
    run_checked(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, "strb_none");
    run_checked(0, 1'b0, 32'h10, 32'h0, 4'hF, "strb_none_read");
    bus_idle(0);
`endif

    for (int i = 0; i < 300; i++) begin
      int          d;
      int          kind;
      logic [31:0] a;
      d = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 9));
      if (kind < 7)       a = 32'($urandom_range(0, NREGS - 1)) * 4;
      else if (kind == 7) a = 32'(4 * NREGS) + 32'($urandom_range(0, 63)) * 4;
      else if (kind == 8) a = 32'($urandom_range(0, NREGS - 1)) * 4 + 32'($urandom_range(1, 3));
      else                a = $urandom;
      run_checked(d, $urandom_range(0, 1) == 1, a, $urandom, 4'($urandom), "rand");
      if ($urandom_range(0, 3) == 0) bus_idle(d);
    end
    bus_idle(0);
    bus_idle(1);

    // Reset during the access phase of a waited write.
    @(negedge pclk);
    psel[1] = 1; penable[1] = 0; pwrite[1] = 1; paddr[1] = 32'h14; pwdata[1] = 32'hCAFEF00D; pstrb[1] = 4'hF;
    @(negedge pclk);
    penable[1] = 1;
    @(negedge pclk);
    preset = 1'b1;
    @(negedge pclk);
    preset = 1'b0;
    psel[1] = 0; penable[1] = 0;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_mid_pready", {31'h0, pready[d]}, 32'h0);
      chk("rst_mid_pslverr", {31'h0, pslverr[d]}, 32'h0);
      chk("rst_mid_prdata", prdata[d], 32'h0);
    end
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < NREGS; r++) begin
        run_checked(d, 1'b0, 32'(4 * r), 32'h0, 4'hF, "rst_read");
      end
      bus_idle(d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_apb_slave_regfile
`default_nettype wire
